// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encodings and small decode helpers.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_CALC = 2'b10,
        S_FIX  = 2'b11
    } state_e;

    // Divide operations are the ones with op[1] set.
    function automatic logic isDivOp(input logic [1:0] opCode);
        return (opCode == OP_DIV) || (opCode == OP_DIVU);
    endfunction

    // Signed operations are the ones with op[0] clear.
    function automatic logic isSignedOp(input logic [1:0] opCode);
        return (opCode == OP_MULT) || (opCode == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remainder_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diffLo;
    logic             fits;

    // Trial subtraction; the low WIDTH bits of the difference are exact
    // whenever the shifted remainder is at least the divisor.
    always_comb begin
        shifted       = {remainder_in, dividend_bit};
        diffLo        = shifted[WIDTH-1:0] - divisor;
        fits          = (shifted >= {1'b0, divisor});
        q_bit         = fits;
        remainder_out = fits ? diffLo : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers. Operands are
// latched on an accepted start, converted to magnitudes in PREP, iterated
// for WIDTH cycles in CALC (shift-add multiply or restoring divide) and
// sign-corrected into HI/LO in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e state_q, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] rawA_q, rawB_q;
    logic [WIDTH-1:0] srcB_q;
    logic [WIDTH-1:0] accHi_q, accLo_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             negQ_q, negR_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             dbz_q;

    logic acceptStart;
    logic hostWrite;
    logic doPrep;
    logic doCalc;
    logic doFix;

    logic             signedOp;
    logic             aNeg, bNeg;
    logic [WIDTH-1:0] aMag, bMag;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mulSum;

    logic [WIDTH-1:0] stepRem;
    logic             stepQ;

    logic [2*WIDTH-1:0] prodMag;
    logic [WIDTH-1:0]   fixHi, fixLo;
    logic               fixDbz;

    // State register; reset and flush both return the engine to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed walk IDLE->PREP->CALC(WIDTH cycles)->FIX,
    // with flush aborting any in-flight operation.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start && !flush) state_d = S_PREP;
            S_PREP: state_d = S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Control strobes decoded from the current state; flush suppresses
    // every datapath update of an in-flight operation.
    always_comb begin
        acceptStart = (state_q == S_IDLE) && start && !flush;
        hostWrite   = (state_q == S_IDLE);
        doPrep      = (state_q == S_PREP) && !flush;
        doCalc      = (state_q == S_CALC) && !flush;
        doFix       = (state_q == S_FIX)  && !flush;
    end

    // Operand magnitudes and result signs for the PREP cycle.
    always_comb begin
        signedOp = isSignedOp(op_q);
        aNeg     = signedOp && rawA_q[WIDTH-1];
        bNeg     = signedOp && rawB_q[WIDTH-1];
        aMag     = aNeg ? -rawA_q : rawA_q;
        bMag     = bNeg ? -rawB_q : rawB_q;
    end

    // Shift-add multiply step: add the multiplicand when the current
    // multiplier bit (LSB of the low half) is set, then shift right.
    always_comb begin
        addend = accLo_q[0] ? srcB_q : '0;
        mulSum = {1'b0, accHi_q} + {1'b0, addend};
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .remainder_in (accHi_q),
        .dividend_bit (accLo_q[WIDTH-1]),
        .divisor      (srcB_q),
        .remainder_out(stepRem),
        .q_bit        (stepQ)
    );

    // Final sign correction and the divide-by-zero override for FIX.
    always_comb begin
        prodMag = {accHi_q, accLo_q};
        fixHi   = accHi_q;
        fixLo   = accLo_q;
        fixDbz  = 1'b0;
        if (isDivOp(op_q)) begin
            if (rawB_q == '0) begin
                fixHi  = rawA_q;
                fixLo  = '1;
                fixDbz = 1'b1;
            end else begin
                fixLo = negQ_q ? -accLo_q : accLo_q;
                fixHi = negR_q ? -accHi_q : accHi_q;
            end
        end else begin
            {fixHi, fixLo} = negQ_q ? -prodMag : prodMag;
        end
    end

    // Datapath and architectural registers: host writes while idle,
    // operand capture, iteration, and result commit with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_MULT;
            rawA_q  <= '0;
            rawB_q  <= '0;
            srcB_q  <= '0;
            accHi_q <= '0;
            accLo_q <= '0;
            negQ_q  <= 1'b0;
            negR_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (hostWrite && hi_we) begin
                hi_q <= wdata;
            end
            if (hostWrite && lo_we) begin
                lo_q <= wdata;
            end

            if (acceptStart) begin
                op_q   <= op;
                rawA_q <= a;
                rawB_q <= b;
                dbz_q  <= 1'b0;
            end

            if (doPrep) begin
                accHi_q <= '0;
                cnt_q   <= CNT_W'(WIDTH - 1);
                negQ_q  <= aNeg ^ bNeg;
                negR_q  <= aNeg;
                if (isDivOp(op_q)) begin
                    srcB_q  <= bMag;
                    accLo_q <= aMag;
                end else begin
                    srcB_q  <= aMag;
                    accLo_q <= bMag;
                end
            end

            if (doCalc) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (isDivOp(op_q)) begin
                    accHi_q <= stepRem;
                    accLo_q <= {accLo_q[WIDTH-2:0], stepQ};
                end else begin
                    accHi_q <= mulSum[WIDTH:1];
                    accLo_q <= {mulSum[0], accLo_q[WIDTH-1:1]};
                end
            end

            if (doFix) begin
                hi_q   <= fixHi;
                lo_q   <= fixLo;
                dbz_q  <= fixDbz;
                done_q <= 1'b1;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        hi          = hi_q;
        lo          = lo_q;
        busy        = (state_q != S_IDLE);
        done        = done_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle, iterative multiply/divide unit for the MIPS pipeline's EX stage.
- Generalises the combinational alu (a, b, 2-bit op, signedness) to a WIDTH-parametrised sequential engine that owns the HI/LO registers.
- Shift-add multiply and restoring divide; start/busy/done handshake; flush input for pipeline exceptions.
- Pipeline stalls while busy is high.

Parameters:
WIDTH, 32, operand width and HI/LO register width (must be >= 4).

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request new operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
flush  input  1  abort in-flight operation
hi_we  input  1  write wdata to HI (mthi)
lo_we  input  1  write wdata to LO (mtlo)
wdata  input  WIDTH  HI/LO write data
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)
busy  output  1  operation in flight
done  output  1  one-cycle pulse in the cycle HI/LO take the result
div_by_zero  output  1  sticky-until-next-start flag: last divide had b=0

Behaviour:
- Reset (rst=1 at an edge, any state, overrides everything): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE. Mid-operation reset discards the operation; no done.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE: start=1 and flush=0 latch op, a, b; go to PREP; busy=1 from the next cycle. div_by_zero clears on accept.
- PREP (1 cycle): signed ops take magnitudes of a and b; record result signs. Signed product/quotient sign = a[MSB] XOR b[MSB]; remainder sign = a[MSB]. Unsigned ops use raw values.
- CALC: exactly WIDTH cycles, counter WIDTH-1 down to 0.
  - Multiply: 2*WIDTH accumulator shift-add, one multiplier bit per cycle.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- FIX (1 cycle): conditional two's-complement negation.
  - Multiply: {hi,lo} = 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - done=1 this cycle only; busy=0 from the next cycle; state IDLE.
- Latency: start sampled at edge E0; hi/lo/done update at edge E(WIDTH+2), i.e. 34 cycles for WIDTH=32. Back-to-back start accepted in the cycle after done.
- Divide by zero (b=0): same latency; hi=a (raw), lo=all ones, div_by_zero=1.
- Signed overflow, DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
- start while busy=1: ignored, not queued.
- flush=1 in any non-IDLE state: next state IDLE, busy=0 next cycle, no done, hi/lo unchanged.
- flush and start in the same IDLE cycle: flush wins; start ignored.
- hi_we/lo_we: honoured only when busy=0; hi/lo update at the next edge; ignored while busy.
- hi_we/lo_we together with an accepted start: the write applies, and the result overwrites it at FIX.
- FIX and a write never coincide, because busy=1 during FIX.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - State encodings S_IDLE, S_PREP, S_CALC, S_FIX.
  - Helper to test for a divide op (op[1]).
- One sub-module: div_step, combinational restoring step (remainder_in, dividend_bit, divisor -> remainder_out, q_bit), WIDTH-parametrised and unit-testable on its own.
- Multiply path stays inline.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at E0 -> hi=0xFFFFFFFE, lo=0x00000001, done high exactly one cycle after E34, busy high E1..E34.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=7 b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU a=0x1234 b=0 -> hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; next accepted start clears the flag.
5. start accepted at E0; second start at E5 with different operands -> ignored, only the first result appears. flush at E10 -> busy=0 after E11, no done, hi/lo unchanged. lo_we at E8 (busy) -> ignored.
6. rst asserted at E20 of a DIV -> after E21 hi=lo=0, busy=done=0. Then lo_we wdata=0xA5A5A5A5 with start=1 op=MULTU a=2 b=3 in the same cycle -> lo=0xA5A5A5A5 next cycle, then lo=6, hi=0 at done.
